// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: request mode encodings,
// counter sizing and the address range helper.
package mem_responder_pkg;

    localparam logic MEMREQ_READ  = 1'b0;
    localparam logic MEMREQ_WRITE = 1'b1;

    localparam int CNT_W = 3;

    // True when base <= addr < base + 4*2^aw. The comparison uses 33 bits so a
    // window that ends at the top of the 32-bit space cannot wrap.
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input int unsigned aw);
        logic [32:0] a_ext;
        logic [32:0] lo_ext;
        logic [32:0] hi_ext;
        a_ext  = {1'b0, addr};
        lo_ext = {1'b0, base};
        hi_ext = lo_ext + (33'd4 << aw);
        return (a_ext >= lo_ext) && (a_ext < hi_ext);
    endfunction

endpackage

// File: rtl/mem_responder_bram_bytewrite.sv
// Single-port 32-bit word RAM with per-byte write enables and a registered
// read port, written so FPGA tools map it onto block RAM.
module bram_bytewrite #(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic [3:0]            we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**ADDR_WIDTH];
    logic [31:0] rdata_q;

    // Read-first access: byte lanes commit and the old word is registered.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Slave end of the single-outstanding memory request port. Accepts a request,
// waits a fixed latency, performs the RAM access on the edge entering RESP and
// returns a one-cycle response, flagging out-of-range and overlapping requests.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int          ADDR_WIDTH = 14,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        request_enable,
    input  logic        req_mode,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        response_enable,
    output logic [31:0] resp_data,
    output logic        busy,
    output logic        access_fault,
    output logic        protocol_error
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    if (LATENCY < 1 || LATENCY > 8) begin : g_latency_check
        $error("mem_responder: LATENCY must be in 1..8");
    end

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  perr_q, perr_d;
    logic                  mode_q, mode_d;
    logic                  in_range_q, in_range_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;

    logic                  accept;
    logic                  req_in_range;
    logic [ADDR_WIDTH-1:0] req_idx;
    logic                  fire;
    logic                  ram_mode;
    logic                  ram_in_range;
    logic [ADDR_WIDTH-1:0] ram_idx;
    logic [31:0]           ram_wdata;
    logic [3:0]            ram_wstrb;
    logic                  ram_en;
    logic [3:0]            ram_we;
    logic [31:0]           ram_rdata;

    assign accept       = (state_q == ST_IDLE) && request_enable;
    assign req_in_range = addr_in_range(req_addr, BASE_ADDR, ADDR_WIDTH);
    assign req_idx      = ADDR_WIDTH'((req_addr - BASE_ADDR) >> 2);

    // Control registers; reset cancels any pending access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            perr_q  <= perr_d;
        end
    end

    // Request payload latches; only meaningful while an access is in flight.
    always_ff @(posedge clk) begin
        mode_q     <= mode_d;
        in_range_q <= in_range_d;
        idx_q      <= idx_d;
        wdata_q    <= wdata_d;
        wstrb_q    <= wstrb_d;
    end

    // Next state, latency countdown and sticky protocol violation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        perr_d  = perr_q | (request_enable && (state_q != ST_IDLE));
        case (state_q)
            ST_IDLE: begin
                if (request_enable) begin
                    if (LATENCY == 1) begin
                        state_d = ST_RESP;
                    end else begin
                        cnt_d   = CNT_W'(LATENCY - 1);
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Capture the request payload at acceptance, otherwise hold it.
    always_comb begin
        mode_d     = mode_q;
        in_range_d = in_range_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        if (accept) begin
            mode_d     = req_mode;
            in_range_d = req_in_range;
            idx_d      = req_idx;
            wdata_d    = req_wdata;
            wstrb_d    = req_wstrb;
        end
    end

    // RAM port: access fires on the edge entering RESP. With LATENCY=1 that is
    // the acceptance edge itself, so the live request drives the port.
    always_comb begin
        if (LATENCY == 1) begin
            fire         = accept;
            ram_mode     = req_mode;
            ram_in_range = req_in_range;
            ram_idx      = req_idx;
            ram_wdata    = req_wdata;
            ram_wstrb    = req_wstrb;
        end else begin
            fire         = (state_q == ST_WAIT) && (cnt_q == CNT_W'(1));
            ram_mode     = mode_q;
            ram_in_range = in_range_q;
            ram_idx      = idx_q;
            ram_wdata    = wdata_q;
            ram_wstrb    = wstrb_q;
        end
        ram_en = fire && ram_in_range;
        ram_we = (ram_en && (ram_mode == MEMREQ_WRITE)) ? ram_wstrb : 4'b0000;
    end

    bram_bytewrite #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_idx),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // Outputs decode registered state only; read data is forced to 0 unless
    // this is the response to an in-range read.
    always_comb begin
        response_enable = (state_q == ST_RESP);
        access_fault    = (state_q == ST_RESP) && !in_range_q;
        busy            = (state_q != ST_IDLE);
        protocol_error  = perr_q;
        resp_data       = '0;
        if ((state_q == ST_RESP) && in_range_q && (mode_q == MEMREQ_READ)) begin
            resp_data = ram_rdata;
        end
    end

endmodule
